// File: rtl/rv_serial_pkg.sv
// Shared definitions for the digit-serial register file family (RV32E/RV32I).
// Holds register-count presets, the FSM state type and the digit-count helper.
package rv_serial_pkg;

  localparam int REGS_RV32E = 16;
  localparam int REGS_RV32I = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Number of clocks needed to move a whole word through a digit-wide path.
  function automatic int digit_count(input int xlen, input int digit_w);
    return xlen / digit_w;
  endfunction

endpackage

// File: rtl/digit_shift_reg.sv
// One register-file word that rotates right by DIGIT_W per enabled clock.
// The digit entering at the top is either the outgoing low digit or a load digit.
module digit_shift_reg #(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en_i,
  input  logic               load_en_i,
  input  logic [DIGIT_W-1:0] load_digit_i,
  output logic [DIGIT_W-1:0] low_digit_o
);

  logic [XLEN-1:0]    word_q;
  logic [XLEN-1:0]    word_d;
  logic [DIGIT_W-1:0] top_digit;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    top_digit = load_en_i ? load_digit_i : word_q[DIGIT_W-1:0];
    word_d    = word_q;
    if (shift_en_i) begin
      word_d = (word_q >> DIGIT_W) | (XLEN'(top_digit) << (XLEN - DIGIT_W));
    end
  end

  // NOTE: storage of this kind is often left unreset, but reset must wipe every
  // register here (including mid-rotation), so each word takes the async reset.
  // Sequential state uses <= so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign low_digit_o = word_q[DIGIT_W-1:0];

endmodule

// File: rtl/serial_regfile_mp.sv
// Digit-serial register file with a built-in rotation sequencer: one start
// rotates every register once, reading two words and writing one.
module serial_regfile_mp
  import rv_serial_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = REGS_RV32E,
  parameter int DIGIT_W  = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(NUM_REGS)-1:0] rd_sel1,
  input  logic [$clog2(NUM_REGS)-1:0] rd_sel2,
  input  logic [$clog2(NUM_REGS)-1:0] wr_sel,
  input  logic                        wr_en,
  input  logic [XLEN-1:0]             wr_word,
  output logic [XLEN-1:0]             rd_word1,
  output logic [XLEN-1:0]             rd_word2,
  output logic                        busy,
  output logic                        done
);

  localparam int SEL_W = $clog2(NUM_REGS);
  localparam int N     = digit_count(XLEN, DIGIT_W);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if ((DIGIT_W < 1) || (DIGIT_W > XLEN) || ((XLEN % DIGIT_W) != 0)) begin : g_bad_digit_w
    $error("serial_regfile_mp: DIGIT_W=%0d must divide XLEN=%0d", DIGIT_W, XLEN);
  end

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEL_W-1:0]   rd_sel1_q;
  logic [SEL_W-1:0]   rd_sel2_q;
  logic [SEL_W-1:0]   wr_sel_q;
  logic               wr_en_q;
  logic [XLEN-1:0]    wr_buf_q;
  logic [XLEN-1:0]    cap1_q;
  logic [XLEN-1:0]    cap2_q;
  logic               busy_q;
  logic               done_q;

  logic               run;
  logic [DIGIT_W-1:0] low_digit [NUM_REGS];
  logic [DIGIT_W-1:0] rd1_digit;
  logic [DIGIT_W-1:0] rd2_digit;

  function automatic logic [XLEN-1:0] shift_in(input logic [XLEN-1:0]    word,
                                               input logic [DIGIT_W-1:0] digit);
    return (word >> DIGIT_W) | (XLEN'(digit) << (XLEN - DIGIT_W));
  endfunction

  assign run = (state_q == ST_RUN);

  // Register 0 is hard-wired to zero when ZERO_REG is set: no storage, writes vanish.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
      assign low_digit[r] = '0;
    end else begin : g_store
      logic wr_hit;
      assign wr_hit = wr_en_q && (wr_sel_q == SEL_W'(r));
      digit_shift_reg #(
        .XLEN    (XLEN),
        .DIGIT_W (DIGIT_W)
      ) u_word (
        .clk          (clk),
        .rst          (rst),
        .shift_en_i   (run),
        .load_en_i    (wr_hit),
        .load_digit_i (wr_buf_q[DIGIT_W-1:0]),
        .low_digit_o  (low_digit[r])
      );
    end
  end

  // Low digits are taken before the write digit enters at the top, so a read of
  // the write target sees the pre-write value.
  assign rd1_digit = low_digit[rd_sel1_q];
  assign rd2_digit = low_digit[rd_sel2_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_sel1_q <= '0;
      rd_sel2_q <= '0;
      wr_sel_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_buf_q  <= '0;
      cap1_q    <= '0;
      cap2_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rd_sel1_q <= rd_sel1;
            rd_sel2_q <= rd_sel2;
            wr_sel_q  <= wr_sel;
            wr_en_q   <= wr_en;
            wr_buf_q  <= wr_word;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          wr_buf_q <= wr_buf_q >> DIGIT_W;
          cap1_q   <= shift_in(cap1_q, rd1_digit);
          cap2_q   <= shift_in(cap2_q, rd2_digit);
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign rd_word1 = cap1_q;
  assign rd_word2 = cap2_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_regfile_mp.sv
// Bench for serial_regfile_mp: directed vector table on the default build,
// hand-written corner sequences, and a word-level model sweep over parameter sets.
module tb_serial_regfile_mp;

  int tests = 0;
  int fails = 0;

  logic        clk;
  logic        rst;
  logic        rst_sw;
  logic        start;
  logic [3:0]  rd_sel1, rd_sel2, wr_sel;
  logic        wr_en;
  logic [31:0] wr_word;
  logic [31:0] rd_word1, rd_word2;
  logic        busy, done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_regfile_mp #(
    .XLEN     (32),
    .NUM_REGS (16),
    .DIGIT_W  (2),
    .ZERO_REG (1)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rd_sel1  (rd_sel1),
    .rd_sel2  (rd_sel2),
    .wr_sel   (wr_sel),
    .wr_en    (wr_en),
    .wr_word  (wr_word),
    .rd_word1 (rd_word1),
    .rd_word2 (rd_word2),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic [3:0] w,
                        input logic we, input logic [31:0] wd);
    rd_sel1 = a;
    rd_sel2 = b;
    wr_sel  = w;
    wr_en   = we;
    wr_word = wd;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
    end
  endtask

  typedef struct {
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  ws;
    logic        we;
    logic [31:0] wd;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [11];

  // Parameter sweep: each block owns a DUT, a word-level model and its own stimulus.
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int D  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 32;
    localparam int NR = (g == 0) ? 32 : (g == 1) ? 32 : 16;
    localparam int ZR = (g == 0 || g == 3) ? 1 : 0;
    localparam int N  = 32 / D;
    localparam int SW = $clog2(NR);

    logic          fin;
    logic          start_s, wen_s, busy_s, done_s;
    logic [SW-1:0] s1_s, s2_s, ws_s;
    logic [31:0]   wword_s, r1_s, r2_s;
    logic [31:0]   model [NR];

    serial_regfile_mp #(
      .XLEN     (32),
      .NUM_REGS (NR),
      .DIGIT_W  (D),
      .ZERO_REG (ZR)
    ) u_sw (
      .clk      (clk),
      .rst      (rst_sw),
      .start    (start_s),
      .rd_sel1  (s1_s),
      .rd_sel2  (s2_s),
      .wr_sel   (ws_s),
      .wr_en    (wen_s),
      .wr_word  (wword_s),
      .rd_word1 (r1_s),
      .rd_word2 (r2_s),
      .busy     (busy_s),
      .done     (done_s)
    );

    task automatic rot(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic [SW-1:0] w,
                       input logic we, input logic [31:0] wd, input string tag);
      int          edges;
      logic [31:0] e1, e2;
      e1      = model[a];
      e2      = model[b];
      s1_s    = a;
      s2_s    = b;
      ws_s    = w;
      wen_s   = we;
      wword_s = wd;
      start_s = 1'b1;
      @(posedge clk);
      #1;
      start_s = 1'b0;
      edges   = 1;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk);
        #1;
        edges++;
        if (done_s) break;
      end
      check($sformatf("cfg%0d_%s_rd1", g, tag), r1_s, e1);
      check($sformatf("cfg%0d_%s_rd2", g, tag), r2_s, e2);
      check($sformatf("cfg%0d_%s_latency", g, tag), 64'(edges), 64'(N + 1));
      if (we && !(ZR != 0 && w == '0)) model[w] = wd;
    endtask

    initial begin
      fin     = 1'b0;
      start_s = 1'b0;
      s1_s    = '0;
      s2_s    = '0;
      ws_s    = '0;
      wen_s   = 1'b0;
      wword_s = '0;
      for (int i = 0; i < NR; i++) model[i] = '0;
      #1;
      wait (!rst_sw);
      @(posedge clk);
      #1;
      rot('0, '0, '0, 1'b1, 32'hFFFF_FFFF, "wr_r0");
      rot('0, SW'(1), '0, 1'b0, 32'h0, "rd_r0");
      for (int k = 0; k < 20; k++) begin
        logic [SW-1:0] a, b, w;
        logic          we;
        a  = SW'($urandom_range(NR - 1, 0));
        b  = SW'($urandom_range(NR - 1, 0));
        w  = (k % 3 == 0) ? a : SW'($urandom_range(NR - 1, 0));
        we = 1'($urandom_range(1, 0));
        rot(a, b, w, we, $urandom, $sformatf("rnd%0d", k));
      end
      fin = 1'b1;
    end
  end

  initial begin
    int edges;

    rst     = 1'b1;
    rst_sw  = 1'b1;
    start   = 1'b0;
    rd_sel1 = '0;
    rd_sel2 = '0;
    wr_sel  = '0;
    wr_en   = 1'b0;
    wr_word = '0;

    vecs[0]  = '{4'd3,  4'd5,  4'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{4'd3,  4'd5,  4'd7,  1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
    vecs[2]  = '{4'd7,  4'd7,  4'd0,  1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3]  = '{4'd6,  4'd8,  4'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[4]  = '{4'd0,  4'd0,  4'd4,  1'b1, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[5]  = '{4'd4,  4'd7,  4'd4,  1'b1, 32'hCAFE_F00D, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[6]  = '{4'd4,  4'd4,  4'd0,  1'b0, 32'h0000_0000, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[7]  = '{4'd0,  4'd7,  4'd0,  1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[8]  = '{4'd0,  4'd4,  4'd0,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D};
    vecs[9]  = '{4'd15, 4'd1,  4'd15, 1'b1, 32'hA5A5_5A5A, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{4'd15, 4'd7,  4'd0,  1'b0, 32'h0000_0000, 32'hA5A5_5A5A, 32'hDEAD_BEEF};

    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    rst_sw = 1'b0;
    #1;
    check("reset_rd_word1", rd_word1, 32'h0);
    check("reset_rd_word2", rd_word2, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      launch(vecs[i].s1, vecs[i].s2, vecs[i].ws, vecs[i].we, vecs[i].wd);
      check($sformatf("vec%0d_busy", i), busy, 1'b1);
      wait_done(edges);
      check($sformatf("vec%0d_latency", i), 64'(edges + 1), 64'd17);
      check($sformatf("vec%0d_rd1", i), rd_word1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rd_word2, vecs[i].e2);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), done, 1'b0);
      check($sformatf("vec%0d_rd1_hold", i), rd_word1, vecs[i].e1);
    end

    // start while busy must be ignored and its inputs not sampled
    launch(4'd7, 4'd4, 4'd0, 1'b0, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    rd_sel1 = 4'd4;
    rd_sel2 = 4'd4;
    wr_sel  = 4'd9;
    wr_en   = 1'b1;
    wr_word = 32'h9999_9999;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_ignore_busy", busy, 1'b1);
    wait_done(edges);
    check("busy_ignore_latency", 64'(edges), 64'd11);
    check("busy_ignore_rd1", rd_word1, 32'hDEAD_BEEF);
    check("busy_ignore_rd2", rd_word2, 32'hCAFE_F00D);

    // back-to-back: start presented in the done cycle
    launch(4'd9, 4'd9, 4'd10, 1'b1, 32'h0BAD_C0DE);
    check("b2b_busy", busy, 1'b1);
    check("b2b_done_low", done, 1'b0);
    wait_done(edges);
    check("b2b_latency", 64'(edges), 64'd16);
    check("b2b_r9_rd1", rd_word1, 32'h0);
    check("b2b_r9_rd2", rd_word2, 32'h0);
    launch(4'd10, 4'd7, 4'd0, 1'b0, 32'h0);
    wait_done(edges);
    check("b2b2_latency", 64'(edges), 64'd16);
    check("b2b2_rd1", rd_word1, 32'h0BAD_C0DE);
    check("b2b2_rd2", rd_word2, 32'hDEAD_BEEF);

    // reset in the middle of a write rotation
    launch(4'd7, 4'd4, 4'd2, 1'b1, 32'h1357_2468);
    repeat (8) @(posedge clk);
    #1;
    check("midrst_busy_before", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rd1", rd_word1, 32'h0);
    check("midrst_rd2", rd_word2, 32'h0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    launch(4'd2, 4'd7, 4'd0, 1'b0, 32'h0);
    wait_done(edges);
    check("postrst_latency", 64'(edges + 1), 64'd17);
    check("postrst_r2", rd_word1, 32'h0);
    check("postrst_r7", rd_word2, 32'h0);
    launch(4'd15, 4'd4, 4'd0, 1'b0, 32'h0);
    wait_done(edges);
    check("postrst_r15", rd_word1, 32'h0);
    check("postrst_r4", rd_word2, 32'h0);

    for (int t = 0; t < 30000; t++) begin
      if (g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin) break;
      @(posedge clk);
    end
    check("sweep_complete", {g_sw[3].fin, g_sw[2].fin, g_sw[1].fin, g_sw[0].fin}, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_regfile_mp.md
# serial_regfile_mp

Parametrised digit-serial register file with a built-in rotation sequencer, the next-generation replacement for the fixed 2-bit, 16-entry serial register file in the RV32E core. One `start` runs a full rotation of every register. During that rotation the block serialises two read words and deserialises one write word, so the core hands over and receives whole words and no longer runs its own shift counter. It sits between the core's decode/execute control and the ALU operand registers, and is sized for RV32E (16 registers) or RV32I (32 registers).

## Interface
Parameters:
- `XLEN`, 32: register width in bits.
- `NUM_REGS`, 16: register count; 16 (RV32E) or 32 (RV32I).
- `DIGIT_W`, 2: bits moved per clock; must divide `XLEN`, range 1..`XLEN`.
- `ZERO_REG`, 1: when 1, register 0 reads 0 and ignores writes.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  request one rotation; accepted only when `busy`=0.
- `rd_sel1`  in  `$clog2(NUM_REGS)`  read port 1 select, sampled at accept.
- `rd_sel2`  in  `$clog2(NUM_REGS)`  read port 2 select, sampled at accept.
- `wr_sel`  in  `$clog2(NUM_REGS)`  write select, sampled at accept.
- `wr_en`  in  1  perform write this rotation, sampled at accept.
- `wr_word`  in  `XLEN`  write data, sampled at accept.
- `rd_word1`  out  `XLEN`  assembled read word for port 1.
- `rd_word2`  out  `XLEN`  assembled read word for port 2.
- `busy`  out  1  rotation in progress.
- `done`  out  1  one-cycle pulse; rotation finished and `rd_word*` valid.

## Operation
- Reset values:
  - all registers 0;
  - `rd_word1`/`rd_word2` 0;
  - `busy` 0, `done` 0;
  - digit counter 0;
  - FSM in IDLE.
- Reset asserted mid-rotation aborts it and clears the entire register contents. No partial write survives.
- The FSM has two states, IDLE and RUN.
- IDLE → RUN on `start`=1:
  - latch `rd_sel1`, `rd_sel2`, `wr_sel`, `wr_en` and `wr_word` into a shift buffer;
  - clear the counter;
  - `busy`←1.
- On each RUN cycle:
  - every register rotates right by `DIGIT_W`;
  - the low digit wraps to the top, except the write target (when the latched `wr_en`=1), which takes the low digit of the write shift buffer instead;
  - the write buffer shifts right by `DIGIT_W`;
  - each read capture register shifts right by `DIGIT_W`, and the selected register's current low digit enters at the top;
  - counter +1.
- RUN → IDLE when the counter reaches `N-1`, where `N = XLEN/DIGIT_W`, on the same edge that shifts the last digit. `busy`←0 and `done`←1 for exactly one cycle.
- Reads return the pre-write value when a read select equals `wr_sel` (read-before-write within the rotation).
- Both read ports may select the same register.
- With `ZERO_REG`=1, a read of register 0 yields 0 and a write to register 0 is dropped. Register 0's storage stays 0.
- `rd_word*` hold their value from `done` until the next accepted `start`.
- `start` while `busy`=1 is ignored; the inputs are not sampled.
- After every rotation each non-written register holds its original value, because the full `XLEN` rotation realigns bit 0.
- Any `DIGIT_W` that does not divide `XLEN` is an elaboration error (assertion).

## Timing
- `start` sampled high at edge k, with `busy`=0, gives:
  - `busy`=1 after edge k;
  - shifting on edges k+1 … k+N;
  - `done`=1 and `busy`=0 after edge k+N.
- Total latency is N+1 cycles: 17 for 32/2, 33 for 32/1, 2 for `DIGIT_W`=`XLEN`.
- `start` held high during the `done` cycle is accepted at that edge, so rotations run back-to-back with no idle gap.
- The written value is visible to a rotation accepted at or after the `done` edge.

## Structure
- Shared package `rv_serial_pkg` holds:
  - `REGS_RV32E`=16 and `REGS_RV32I`=32;
  - the `digit_count(XLEN, DIGIT_W)` function;
  - the state enum for IDLE/RUN.
- One natural sub-module, `digit_shift_reg`: a single `XLEN` register that rotates by `DIGIT_W` with a load-digit mux. It is instantiated `NUM_REGS` times, or `NUM_REGS-1` times when `ZERO_REG`=1.
- Read-digit muxes, write buffer and counter live in the top level.

## Test plan
- Reset, then rotate reading registers 3 and 5 → `rd_word1`=`rd_word2`=0, `done` exactly 17 cycles after `start`.
- Write `0xDEADBEEF` to register 7, then read registers 7 and 7 → both `rd_word` = `0xDEADBEEF`; the other registers still read 0.
- Register 4 holds `0x12345678`; in one rotation write `0xCAFEF00D` to it and read it → `rd_word1`=`0x12345678`; the next rotation reads `0xCAFEF00D`.
- `ZERO_REG`=1: write `0xFFFFFFFF` to register 0 → it reads 0. With `ZERO_REG`=0 the same sequence reads `0xFFFFFFFF`.
- Assert `rst` at cycle 8 of a write rotation to register 2 → all outputs 0 immediately and register 2 reads 0. A `start` during `busy` is ignored; `start` in the `done` cycle begins the next rotation.
- Sweep `DIGIT_W` ∈ {1,2,4,32} and `NUM_REGS` ∈ {16,32} with random write/read sequences against a word-level model → results match, latency = `XLEN/DIGIT_W`+1.
